// File: rtl/instr_prefetch.sv
// Instruction prefetch queue.
// Fetches sequential instructions from imem with at most one request in
// flight and buffers them in a DEPTH-entry first-word-fall-through queue.
// A redirect flushes the queue and restarts fetch at redirect_pc. A
// response to a request that was overtaken by a redirect is dropped.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous reset, active low
//   redirect     taken branch/jump: flush and restart fetch
//   redirect_pc  new fetch address, sampled while redirect=1
//   imem_req     one-cycle fetch request strobe
//   imem_addr    fetch address (0 while imem_req=0)
//   imem_rvalid  fetch response valid
//   imem_rdata   fetched instruction
//   out_valid    queue head valid
//   out_ready    consumer accepts head
//   out_pc       PC of head instruction (0 when empty)
//   out_instr    head instruction (0 when empty)
//
// Configuration
//   PREFETCH_BYPASS_EN  when defined, a response arriving while the queue
//                       is empty is presented on out_* in the same cycle.
//                       When undefined, all out_* are flop outputs.
//
// DEPTH must be a power of two, at least 2.
module instr_prefetch #(
    parameter int unsigned     PC_W     = 9,
    parameter int unsigned     INS_W    = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_instr
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DISCARD} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PC_W-1:0]    pc_mem_q [DEPTH];
    logic [PC_W-1:0]    pc_mem_d [DEPTH];
    logic [INS_W-1:0]   ins_mem_q [DEPTH];
    logic [INS_W-1:0]   ins_mem_d [DEPTH];
    logic               req_q, req_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [PC_W-1:0]    opc_q, opc_d;
    logic [INS_W-1:0]   oins_q, oins_d;
    logic               issue_c, push_c, pop_c, bypass_c;

    // Same-cycle forwarding of a response into an empty queue
`ifdef PREFETCH_BYPASS_EN
    assign bypass_c = (state_q == WAIT) && imem_rvalid && (count_q == '0) && !redirect;
`else
    assign bypass_c = 1'b0;
`endif

    // A request goes out in ISSUE whenever the queue has room for its answer
    assign issue_c = (state_q == ISSUE) && (count_q < CNT_W'(DEPTH));
    assign push_c  = (state_q == WAIT) && imem_rvalid && !redirect && !(bypass_c && out_ready);
    assign pop_c   = valid_q && out_ready && !redirect;

    // Next-state, queue update and next registered outputs
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pc_mem_d   = pc_mem_q;
        ins_mem_d  = ins_mem_q;

        case (state_q)
            IDLE:    state_d = ISSUE;
            ISSUE:   if (issue_c) state_d = WAIT;
            WAIT:    if (imem_rvalid) begin
                         state_d    = ISSUE;
                         fetch_pc_d = fetch_pc_q + PC_W'(4);
                     end
            DISCARD: if (imem_rvalid) state_d = ISSUE;
            default: state_d = IDLE;
        endcase

        if (push_c) begin
            pc_mem_d[wr_ptr_q]  = fetch_pc_q;
            ins_mem_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        // Redirect wins over push/pop. A request still in flight must be
        // drained in DISCARD; a response arriving in the redirect cycle
        // itself is the one being dropped, so fetch can restart directly.
        if (redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_pc;
            if (issue_c || (((state_q == WAIT) || (state_q == DISCARD)) && !imem_rvalid))
                state_d = DISCARD;
            else
                state_d = ISSUE;
        end

        req_d   = (state_d == ISSUE) && (count_d < CNT_W'(DEPTH));
        addr_d  = req_d ? fetch_pc_d : '0;
        valid_d = (count_d != '0);
        opc_d   = valid_d ? pc_mem_d[rd_ptr_d]  : '0;
        oins_d  = valid_d ? ins_mem_d[rd_ptr_d] : '0;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
            req_q      <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            opc_q      <= '0;
            oins_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pc_mem_q   <= pc_mem_d;
            ins_mem_q  <= ins_mem_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            opc_q      <= opc_d;
            oins_q     <= oins_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

`ifdef PREFETCH_BYPASS_EN
    assign out_valid = valid_q | bypass_c;
    assign out_pc    = bypass_c ? fetch_pc_q : opc_q;
    assign out_instr = bypass_c ? imem_rdata : oins_q;
`else
    assign out_valid = valid_q;
    assign out_pc    = opc_q;
    assign out_instr = oins_q;
`endif

endmodule
